hart_issue_sched: RTL and testbench
===================================

# hart_issue_sched

Parametrised hart issue scheduler for the multithreaded pipeline. It selects, every cycle, which hart the IF stage fetches for. It tracks harts blocked on outstanding I-/D-cache misses and lets the primary hart yield to minor harts for a programmable burst on loads, branches and kills. When every hart is active it switches to round-robin interleaving. It sits between the hart state table (prim/acti masks) and the IF/ID/MEM stages.

## Interface
- NUM_HARTS, 4, number of hardware harts (2..16)
- HID_W, 2, hart ID width, clog2(NUM_HARTS)
- MINOR_BURST, 2, cycles issued to minor harts per primary yield (1..15)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- prim_hstate  in  NUM_HARTS  one-hot primary hart mask (zero allowed)
- acti_hstate  in  NUM_HARTS  active hart mask
- id_hid  in  HID_W  hart of instruction in ID
- is_load  in  1  ID holds a load
- is_branch  in  1  ID holds a conditional branch
- id_hkill  in  1  ID kills hart id_set_hid
- id_set_hid  in  HID_W  target of kill
- ic_miss  in  1  I-cache miss, hart ic_miss_hid
- ic_miss_hid  in  HID_W  missing hart
- ic_fin  in  1  I-cache refill done
- dc_miss  in  1  D-cache miss, hart dc_miss_hid
- dc_miss_hid  in  HID_W  missing hart
- dc_fin  in  1  D-cache refill done
- issue_hstate  out  NUM_HARTS  one-hot hart to fetch, 0 if none
- issue_hid  out  HID_W  encoded issue_hstate (0 when invalid)
- issue_valid  out  1  issue_hstate nonzero
- blk_hstate  out  NUM_HARTS  harts blocked on a miss (registered)
- hart_stall  out  1  miss with no other eligible hart: stall pipeline
- hart_flush  out  1  miss with another eligible hart: flush missing hart's in-flight ins

## Operation
- eligible = acti_hstate & ~blk_hstate; minor = eligible & ~prim_hstate.
- Miss tracking: one outstanding miss per cache; registers ic_busy/ic_hid, dc_busy/dc_hid. ic_miss sets ic_busy, ic_hid<=ic_miss_hid. ic_fin clears ic_busy. Same for D. blk_hstate = onehot(ic_hid)&ic_busy | onehot(dc_hid)&dc_busy. Miss and fin in the same cycle: miss wins (busy stays 1, hid updated).
- Stall/flush (combinational, cycle of miss): other = eligible & ~onehot(miss hid). hart_flush = miss & |other; hart_stall = miss & ~|other. I and D miss together: evaluate with both hids excluded.
- Mode RR (acti_hstate all ones): issue next eligible hart after last_hid, cyclic increasing ID.
- Mode PRIO (otherwise), priority order:
  1. eligible==0 -> issue 0.
  2. burst_cnt>0 and minor!=0 -> next minor after last_hid (round-robin).
  3. prim eligible -> issue prim.
  4. else -> next minor after last_hid.
- Yield trigger (PRIO only): (is_load | is_branch) with id_hid == prim hart, or id_hkill with id_set_hid == prim hart, while minor!=0. It loads burst_cnt<=MINOR_BURST. A kill trigger also forces the current-cycle issue to a minor hart. Triggers while burst_cnt>0 reload it.
- burst_cnt decrements each cycle a minor hart issues while >0. It clears when minor becomes 0.
- last_hid<=issue_hid whenever issue_valid.

## Timing
- Issue outputs are combinational from registered state plus current masks, so they are valid in the same cycle.
- Miss at cycle t: hart blocked from t+1. fin at t: hart eligible at t+1.
- Yield trigger at t: minor issue from t+1 for MINOR_BURST issuing cycles (kill: from t).
- Reset: blk_hstate=0, burst_cnt=0, busy=0, last_hid=NUM_HARTS-1 (first RR pick is hart 0). Outputs follow the inputs; with acti=0, all outputs are 0.
- rst mid-miss discards busy state; a later fin with busy=0 is ignored.

## Configuration
- HART_SCHED_BRANCH_YIELD_EN: when defined, is_branch from the primary hart is a yield trigger. When undefined, only loads and kills trigger yield, and is_branch is ignored.

## Test plan
- NUM_HARTS=4, acti=1111, no misses, 8 cycles -> issue_hid 0,1,2,3,0,1,2,3.
- acti=0111, prim=0001, is_load with id_hid=0 at t, MINOR_BURST=2 -> issue hart1 at t+1, hart2 at t+2, hart0 at t+3.
- acti=1111, ic_miss hid=2 at t -> hart_flush=1, hart_stall=0 at t; blk=0100 from t+1; RR skips 2 until ic_fin at t+k; hart 2 issued again from t+k+1.
- acti=0001, dc_miss hid=0 -> hart_stall=1, hart_flush=0; issue_valid=0 until dc_fin+1.
- acti=0011, prim=0001, id_hkill id_set_hid=0 -> issue_hstate=0010 the same cycle.
- With the macro undefined: is_branch from primary -> issue stays on primary; with it defined -> minor burst starts.

Source files
------------

// File: rtl/hart_issue_sched_if.sv
// Scheduler-side bundle: hart state masks, ID/cache event strobes in, issue selection out.
// master = pipeline/hart-table side, slave = hart_issue_sched.
interface hart_issue_sched_if #(
  parameter int NUM_HARTS = 4,
  parameter int HID_W     = 2
);
  logic [NUM_HARTS-1:0] prim_hstate;
  logic [NUM_HARTS-1:0] acti_hstate;
  logic [HID_W-1:0]     id_hid;
  logic                 is_load;
  logic                 is_branch;
  logic                 id_hkill;
  logic [HID_W-1:0]     id_set_hid;
  logic                 ic_miss;
  logic [HID_W-1:0]     ic_miss_hid;
  logic                 ic_fin;
  logic                 dc_miss;
  logic [HID_W-1:0]     dc_miss_hid;
  logic                 dc_fin;
  logic [NUM_HARTS-1:0] issue_hstate;
  logic [HID_W-1:0]     issue_hid;
  logic                 issue_valid;
  logic [NUM_HARTS-1:0] blk_hstate;
  logic                 hart_stall;
  logic                 hart_flush;

  modport master (
    output prim_hstate, acti_hstate, id_hid, is_load, is_branch, id_hkill, id_set_hid,
    output ic_miss, ic_miss_hid, ic_fin, dc_miss, dc_miss_hid, dc_fin,
    input  issue_hstate, issue_hid, issue_valid, blk_hstate, hart_stall, hart_flush
  );

  modport slave (
    input  prim_hstate, acti_hstate, id_hid, is_load, is_branch, id_hkill, id_set_hid,
    input  ic_miss, ic_miss_hid, ic_fin, dc_miss, dc_miss_hid, dc_fin,
    output issue_hstate, issue_hid, issue_valid, blk_hstate, hart_stall, hart_flush
  );
endinterface

// File: rtl/hart_issue_sched.sv
// Per-cycle IF hart selection: miss blocking, primary-yield minor bursts, round-robin when all active.
// Optional: define HART_SCHED_BRANCH_YIELD_EN to make primary-hart conditional branches yield too.
module hart_issue_sched #(
  parameter int NUM_HARTS   = 4,
  parameter int HID_W       = 2,
  parameter int MINOR_BURST = 2
) (
  input logic               clk,
  input logic               rst,
  hart_issue_sched_if.slave bus
);
  localparam int BW = 4;

  typedef logic [NUM_HARTS-1:0] hmask_t;
  typedef logic [HID_W-1:0]     hid_t;
  typedef logic [HID_W:0]       hsum_t;
  typedef logic [BW-1:0]        burst_t;

  localparam hmask_t ONE        = hmask_t'(1);
  localparam hid_t   LAST_RST   = hid_t'(NUM_HARTS - 1);
  localparam burst_t BURST_LOAD = burst_t'(MINOR_BURST);

  function automatic hmask_t onehot(input hid_t h);
    return ONE << h;
  endfunction

  function automatic hid_t enc(input hmask_t oh);
    hid_t r;
    r = '0;
    for (int j = 0; j < NUM_HARTS; j++)
      if (((oh >> j) & ONE) != '0) r = r | hid_t'(j);
    return r;
  endfunction

  // {found, hid}: first set bit of mask strictly after 'last', wrapping cyclically.
  function automatic hsum_t next_after(input hmask_t mask, input hid_t last);
    hmask_t rot;
    hmask_t low;
    hsum_t  sum;
    rot = hmask_t'({mask, mask} >> (hsum_t'(last) + hsum_t'(1)));
    low = rot & (~rot + ONE);
    sum = hsum_t'(enc(low)) + hsum_t'(last) + hsum_t'(1);
    if (sum >= hsum_t'(NUM_HARTS)) sum = sum - hsum_t'(NUM_HARTS);
    return {|mask, sum[HID_W-1:0]};
  endfunction

  logic   ic_busy_q, ic_busy_d;
  logic   dc_busy_q, dc_busy_d;
  hid_t   ic_hid_q, ic_hid_d;
  hid_t   dc_hid_q, dc_hid_d;
  hid_t   last_hid_q, last_hid_d;
  burst_t burst_cnt_q, burst_cnt_d;
  hmask_t blk_q, blk_d;

  hmask_t eligible;
  hmask_t minor;
  hmask_t prim_live;
  hmask_t miss_mask;
  hmask_t other;
  logic   rr_mode;
  logic   any_miss;
  logic   ld_br;
  logic   prim_is_id;
  logic   prim_is_kill;
  logic   kill_trig;
  logic   yield_trig;
  hsum_t  rr_pick;
  hsum_t  minor_pick;
  logic   issue_v;
  hid_t   issue_id;
  hmask_t issue_oh;

  // One outstanding miss per cache; a miss in the same cycle as a fin re-arms tracking.
  always_comb begin
    ic_busy_d = ic_busy_q;
    ic_hid_d  = ic_hid_q;
    dc_busy_d = dc_busy_q;
    dc_hid_d  = dc_hid_q;
    if (bus.ic_miss) begin
      ic_busy_d = 1'b1;
      ic_hid_d  = bus.ic_miss_hid;
    end else if (bus.ic_fin) begin
      ic_busy_d = 1'b0;
    end
    if (bus.dc_miss) begin
      dc_busy_d = 1'b1;
      dc_hid_d  = bus.dc_miss_hid;
    end else if (bus.dc_fin) begin
      dc_busy_d = 1'b0;
    end
    blk_d = (ic_busy_d ? onehot(ic_hid_d) : '0) | (dc_busy_d ? onehot(dc_hid_d) : '0);
  end

  assign eligible  = bus.acti_hstate & ~blk_q;
  assign minor     = eligible & ~bus.prim_hstate;
  assign prim_live = eligible & bus.prim_hstate;
  assign rr_mode   = &bus.acti_hstate;

  // Stall vs flush depends on whether anyone other than the missing hart(s) can still run.
  assign any_miss  = bus.ic_miss | bus.dc_miss;
  assign miss_mask = (bus.ic_miss ? onehot(bus.ic_miss_hid) : '0)
                   | (bus.dc_miss ? onehot(bus.dc_miss_hid) : '0);
  assign other     = eligible & ~miss_mask;

`ifdef HART_SCHED_BRANCH_YIELD_EN
  assign ld_br = bus.is_load | bus.is_branch;
`else
  logic unused_is_branch;
  assign ld_br            = bus.is_load;
  assign unused_is_branch = bus.is_branch;
`endif

  assign prim_is_id   = |(bus.prim_hstate & onehot(bus.id_hid));
  assign prim_is_kill = |(bus.prim_hstate & onehot(bus.id_set_hid));
  assign kill_trig    = ~rr_mode & (|minor) & bus.id_hkill & prim_is_kill;
  assign yield_trig   = kill_trig | (~rr_mode & (|minor) & ld_br & prim_is_id);

  assign rr_pick    = next_after(eligible, last_hid_q);
  assign minor_pick = next_after(minor, last_hid_q);

  always_comb begin
    issue_v  = 1'b0;
    issue_id = '0;
    if (|eligible) begin
      if (rr_mode) begin
        {issue_v, issue_id} = rr_pick;
      end else if (kill_trig || (burst_cnt_q != '0 && |minor)) begin
        {issue_v, issue_id} = minor_pick;
      end else if (|prim_live) begin
        issue_v  = 1'b1;
        issue_id = enc(prim_live);
      end else begin
        {issue_v, issue_id} = minor_pick;
      end
    end
    issue_oh = issue_v ? onehot(issue_id) : '0;
  end

  // A fresh trigger always reloads the burst, even while one is running.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (yield_trig) begin
      burst_cnt_d = BURST_LOAD;
    end else if (minor == '0) begin
      burst_cnt_d = '0;
    end else if (burst_cnt_q != '0 && |(issue_oh & minor)) begin
      burst_cnt_d = burst_cnt_q - burst_t'(1);
    end
    last_hid_d = issue_v ? issue_id : last_hid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ic_busy_q   <= 1'b0;
      ic_hid_q    <= '0;
      dc_busy_q   <= 1'b0;
      dc_hid_q    <= '0;
      blk_q       <= '0;
      burst_cnt_q <= '0;
      last_hid_q  <= LAST_RST;
    end else begin
      ic_busy_q   <= ic_busy_d;
      ic_hid_q    <= ic_hid_d;
      dc_busy_q   <= dc_busy_d;
      dc_hid_q    <= dc_hid_d;
      blk_q       <= blk_d;
      burst_cnt_q <= burst_cnt_d;
      last_hid_q  <= last_hid_d;
    end
  end

  assign bus.issue_hstate = issue_oh;
  assign bus.issue_hid    = issue_id;
  assign bus.issue_valid  = issue_v;
  assign bus.blk_hstate   = blk_q;
  assign bus.hart_flush   = any_miss & (|other);
  assign bus.hart_stall   = any_miss & ~(|other);
endmodule

// File: tb/tb_hart_issue_sched.sv
// Bench for hart_issue_sched: directed scenarios plus randomized run against a rule-level model.
module tb_hart_issue_sched;
  localparam int N  = 4;
  localparam int HW = 2;
  localparam int MB = 2;
`ifdef HART_SCHED_BRANCH_YIELD_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hart_issue_sched_if #(.NUM_HARTS(N), .HID_W(HW)) bus ();

  hart_issue_sched #(.NUM_HARTS(N), .HID_W(HW), .MINOR_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  // model state
  bit m_icb, m_dcb;
  int m_ich, m_dch, m_last, m_burst;

  function automatic bit has(input logic [3:0] m, input int h);
    return ((m >> h) & 4'h1) != 4'h0;
  endfunction

  function automatic int pick_after(input logic [3:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (has(mask, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_strobes();
    bus.id_hid = '0; bus.is_load = 1'b0; bus.is_branch = 1'b0;
    bus.id_hkill = 1'b0; bus.id_set_hid = '0;
    bus.ic_miss = 1'b0; bus.ic_miss_hid = '0; bus.ic_fin = 1'b0;
    bus.dc_miss = 1'b0; bus.dc_miss_hid = '0; bus.dc_fin = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_strobes();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.acti_hstate = 4'h0; bus.prim_hstate = 4'h0;
    do_reset();
    #1;
    total++;
    if ({bus.issue_hstate, bus.issue_hid, bus.issue_valid, bus.blk_hstate, bus.hart_stall, bus.hart_flush} !== 13'h0)
      $display("FAIL reset_outputs: got hstate=%b hid=%0d v=%b blk=%b st=%b fl=%b, expected all zero",
               bus.issue_hstate, bus.issue_hid, bus.issue_valid, bus.blk_hstate, bus.hart_stall, bus.hart_flush);
    else passed++;
    bus.acti_hstate = 4'hF;
    #1;
    total++;
    if (bus.issue_hstate !== 4'b0001)
      $display("FAIL reset_first_rr: got %b expected 0001", bus.issue_hstate);
    else passed++;
    $display("reset: first rr pick %b", bus.issue_hstate);
    tick();
  endtask

  task automatic test_rr();
    do_reset();
    bus.acti_hstate = 4'hF; bus.prim_hstate = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (bus.issue_hid !== 2'(i % 4) || bus.issue_valid !== 1'b1)
        $display("FAIL rr_seq cyc %0d: got hid=%0d v=%b expected hid=%0d v=1", i, bus.issue_hid, bus.issue_valid, i % 4);
      else passed++;
      $display("rr: cyc %0d issue_hid=%0d", i, bus.issue_hid);
      tick();
    end
  endtask

  task automatic test_load_yield();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001;
    do_reset();
    bus.acti_hstate = 4'b0111; bus.prim_hstate = 4'b0001;
    #1;
    total++;
    if (bus.issue_hstate !== 4'b0001) $display("FAIL load_pre: got %b expected 0001", bus.issue_hstate);
    else passed++;
    tick();
    bus.is_load = 1'b1; bus.id_hid = 2'd0;
    #1;
    total++;
    if (bus.issue_hstate !== 4'b0001) $display("FAIL load_trig_cycle: got %b expected 0001", bus.issue_hstate);
    else passed++;
    tick();
    bus.is_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.issue_hstate !== exp_seq[i])
        $display("FAIL load_burst t+%0d: got %b expected %b", i + 1, bus.issue_hstate, exp_seq[i]);
      else passed++;
      $display("load_yield: t+%0d issue=%b", i + 1, bus.issue_hstate);
      tick();
    end
  endtask

  task automatic test_ic_miss();
    int exp_seq [4];
    exp_seq[0] = 3; exp_seq[1] = 0; exp_seq[2] = 1; exp_seq[3] = 3;
    do_reset();
    bus.acti_hstate = 4'hF;
    tick();
    bus.ic_miss = 1'b1; bus.ic_miss_hid = 2'd2;
    #1;
    total++;
    if (bus.hart_flush !== 1'b1 || bus.hart_stall !== 1'b0 || bus.issue_hid !== 2'd1)
      $display("FAIL ic_miss_cycle: got fl=%b st=%b hid=%0d expected fl=1 st=0 hid=1", bus.hart_flush, bus.hart_stall, bus.issue_hid);
    else passed++;
    tick();
    bus.ic_miss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.blk_hstate !== 4'b0100 || bus.issue_hid !== 2'(exp_seq[i]))
        $display("FAIL ic_blocked %0d: got blk=%b hid=%0d expected blk=0100 hid=%0d", i, bus.blk_hstate, bus.issue_hid, exp_seq[i]);
      else passed++;
      $display("ic_miss: blocked cyc %0d issue_hid=%0d", i, bus.issue_hid);
      tick();
    end
    bus.ic_fin = 1'b1;
    #1;
    total++;
    if (bus.blk_hstate !== 4'b0100 || bus.issue_hid !== 2'd0)
      $display("FAIL ic_fin_cycle: got blk=%b hid=%0d expected blk=0100 hid=0", bus.blk_hstate, bus.issue_hid);
    else passed++;
    tick();
    bus.ic_fin = 1'b0;
    #1;
    total++;
    if (bus.blk_hstate !== 4'b0000 || bus.issue_hid !== 2'd1)
      $display("FAIL ic_after_fin: got blk=%b hid=%0d expected blk=0000 hid=1", bus.blk_hstate, bus.issue_hid);
    else passed++;
    tick();
    #1;
    total++;
    if (bus.issue_hid !== 2'd2) $display("FAIL ic_hart2_back: got %0d expected 2", bus.issue_hid);
    else passed++;
    tick();
  endtask

  task automatic test_dc_stall();
    do_reset();
    bus.acti_hstate = 4'b0001; bus.prim_hstate = 4'b0001;
    bus.dc_miss = 1'b1; bus.dc_miss_hid = 2'd0;
    #1;
    total++;
    if (bus.hart_stall !== 1'b1 || bus.hart_flush !== 1'b0 || bus.issue_hstate !== 4'b0001)
      $display("FAIL dc_miss_cycle: got st=%b fl=%b iss=%b expected st=1 fl=0 iss=0001", bus.hart_stall, bus.hart_flush, bus.issue_hstate);
    else passed++;
    tick();
    bus.dc_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dc_fin = (i == 2);
      #1;
      total++;
      if (bus.issue_valid !== 1'b0 || bus.blk_hstate !== 4'b0001)
        $display("FAIL dc_blocked %0d: got v=%b blk=%b expected v=0 blk=0001", i, bus.issue_valid, bus.blk_hstate);
      else passed++;
      tick();
    end
    bus.dc_fin = 1'b0;
    #1;
    total++;
    if (bus.issue_valid !== 1'b1 || bus.issue_hstate !== 4'b0001)
      $display("FAIL dc_resume: got v=%b iss=%b expected v=1 iss=0001", bus.issue_valid, bus.issue_hstate);
    else passed++;
    $display("dc_stall: resumed issue=%b", bus.issue_hstate);
    tick();
  endtask

  task automatic test_kill();
    do_reset();
    bus.acti_hstate = 4'b0011; bus.prim_hstate = 4'b0001;
    tick();
    bus.id_hkill = 1'b1; bus.id_set_hid = 2'd0;
    #1;
    total++;
    if (bus.issue_hstate !== 4'b0010) $display("FAIL kill_same_cycle: got %b expected 0010", bus.issue_hstate);
    else passed++;
    tick();
    bus.id_hkill = 1'b0;
    #1;
    total++;
    if (bus.issue_hstate !== 4'b0010) $display("FAIL kill_burst: got %b expected 0010", bus.issue_hstate);
    else passed++;
    $display("kill: burst issue=%b", bus.issue_hstate);
    tick();
  endtask

  task automatic test_branch();
    logic [3:0] exp_oh;
    exp_oh = BR_EN ? 4'b0010 : 4'b0001;
    do_reset();
    bus.acti_hstate = 4'b0111; bus.prim_hstate = 4'b0001;
    bus.is_branch = 1'b1; bus.id_hid = 2'd0;
    tick();
    bus.is_branch = 1'b0;
    #1;
    total++;
    if (bus.issue_hstate !== exp_oh) $display("FAIL branch_yield: got %b expected %b", bus.issue_hstate, exp_oh);
    else passed++;
    $display("branch: issue after branch=%b", bus.issue_hstate);
    tick();
  endtask

  task automatic test_random();
    do_reset();
    m_icb = 0; m_dcb = 0; m_ich = 0; m_dch = 0; m_last = N - 1; m_burst = 0;
    for (int c = 0; c < 500; c++) begin
      int pi, exp_id;
      logic [3:0] acti, prim, blk, elig, minor, excl, exp_oh;
      bit rr, kt, yt, mis, do_rst;
      do_rst = ($urandom_range(0, 99) == 0);
      acti = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      pi = $urandom_range(0, 4);
      prim = (pi == 4) ? 4'h0 : 4'(1 << pi);
      bus.acti_hstate = acti; bus.prim_hstate = prim;
      bus.id_hid      = ($urandom_range(0, 1) == 0) ? 2'(pi) : 2'($urandom_range(0, 3));
      bus.is_load     = ($urandom_range(0, 2) == 0);
      bus.is_branch   = ($urandom_range(0, 3) == 0);
      bus.id_hkill    = ($urandom_range(0, 7) == 0);
      bus.id_set_hid  = ($urandom_range(0, 1) == 0) ? 2'(pi) : 2'($urandom_range(0, 3));
      bus.ic_miss     = ($urandom_range(0, 9) == 0);
      bus.ic_miss_hid = 2'($urandom_range(0, 3));
      bus.ic_fin      = ($urandom_range(0, 4) == 0);
      bus.dc_miss     = ($urandom_range(0, 9) == 0);
      bus.dc_miss_hid = 2'($urandom_range(0, 3));
      bus.dc_fin      = ($urandom_range(0, 4) == 0);
      rst = do_rst;
      #1;
      if (do_rst) begin
        m_icb = 0; m_dcb = 0; m_ich = 0; m_dch = 0; m_last = N - 1; m_burst = 0;
        $display("rand: cyc %0d reset", c);
      end else begin
        blk   = (m_icb ? 4'(1 << m_ich) : 4'h0) | (m_dcb ? 4'(1 << m_dch) : 4'h0);
        elig  = acti & ~blk;
        minor = elig & ~prim;
        rr    = (acti == 4'hF);
        kt = !rr && minor != 4'h0 && bus.id_hkill && has(prim, int'(bus.id_set_hid));
        yt = kt || (!rr && minor != 4'h0 && (bus.is_load || (BR_EN && bus.is_branch)) && has(prim, int'(bus.id_hid)));
        if (elig == 4'h0) exp_id = -1;
        else if (rr) exp_id = pick_after(elig, m_last);
        else if (kt || (m_burst > 0 && minor != 4'h0)) exp_id = pick_after(minor, m_last);
        else if ((prim & elig) != 4'h0) exp_id = pi;
        else exp_id = pick_after(minor, m_last);
        exp_oh = (exp_id < 0) ? 4'h0 : 4'(1 << exp_id);
        mis  = bus.ic_miss || bus.dc_miss;
        excl = (bus.ic_miss ? 4'(1 << bus.ic_miss_hid) : 4'h0) | (bus.dc_miss ? 4'(1 << bus.dc_miss_hid) : 4'h0);

        total++;
        if (bus.issue_hstate !== exp_oh) $display("FAIL rand_hstate cyc %0d: got %b expected %b", c, bus.issue_hstate, exp_oh);
        else passed++;
        total++;
        if (bus.issue_hid !== 2'((exp_id < 0) ? 0 : exp_id) || bus.issue_valid !== (exp_id >= 0))
          $display("FAIL rand_hid cyc %0d: got hid=%0d v=%b expected hid=%0d v=%b", c, bus.issue_hid, bus.issue_valid,
                   (exp_id < 0) ? 0 : exp_id, exp_id >= 0);
        else passed++;
        total++;
        if (bus.blk_hstate !== blk) $display("FAIL rand_blk cyc %0d: got %b expected %b", c, bus.blk_hstate, blk);
        else passed++;
        total++;
        if (bus.hart_stall !== (mis && (elig & ~excl) == 4'h0) || bus.hart_flush !== (mis && (elig & ~excl) != 4'h0))
          $display("FAIL rand_stall_flush cyc %0d: got st=%b fl=%b expected st=%b fl=%b", c, bus.hart_stall, bus.hart_flush,
                   mis && (elig & ~excl) == 4'h0, mis && (elig & ~excl) != 4'h0);
        else passed++;
        $display("rand: cyc %0d acti=%b prim=%b blk=%b issue=%b", c, acti, prim, bus.blk_hstate, bus.issue_hstate);

        if (yt) m_burst = MB;
        else if (minor == 4'h0) m_burst = 0;
        else if (m_burst > 0 && exp_id >= 0 && has(minor, exp_id)) m_burst = m_burst - 1;
        if (exp_id >= 0) m_last = exp_id;
        if (bus.ic_miss) begin m_icb = 1; m_ich = int'(bus.ic_miss_hid); end
        else if (bus.ic_fin) m_icb = 0;
        if (bus.dc_miss) begin m_dcb = 1; m_dch = int'(bus.dc_miss_hid); end
        else if (bus.dc_fin) m_dcb = 0;
      end
      tick();
    end
    rst = 1'b0;
    clear_strobes();
  endtask

  initial begin
    rst = 1'b1;
    bus.acti_hstate = 4'h0;
    bus.prim_hstate = 4'h0;
    clear_strobes();
    test_reset();
    test_rr();
    test_load_yield();
    test_ic_miss();
    test_dc_stall();
    test_kill();
    test_branch();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
